// File: rtl/load_store_unit.sv
// RV32I load/store unit: byte/half/word accesses to a word-wide dmem, with
// misaligned accesses split over two cycles (IDLE -> SECOND).
module load_store_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] daddr,
  output logic [31:0] dwdata,
  output logic [3:0]  we,
  input  logic [31:0] drdata
);

  typedef enum logic {IDLE, SECOND} state_e;

  state_e      state_q, state_d;
  logic [31:0] rot_q, rot_d;
  logic [3:0]  lanes_hi_q, lanes_hi_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        store_q, store_d;
  logic [31:0] addr2_q, addr2_d;
  logic [31:0] lo_q, lo_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  logic [1:0]  off;
  logic [3:0]  mask;
  logic [7:0]  lanes;
  logic        legal;
  logic        misal;
  logic        accept;
  logic [31:0] rot;
  logic [31:0] word_addr;
  logic [31:0] hi_sel, lo_sel, raw, load_data;
  logic [1:0]  off_sel;
  logic [2:0]  f3_sel;

  function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] r);
    case (f3)
      3'b000:  extend = {{24{r[7]}}, r[7:0]};
      3'b001:  extend = {{16{r[15]}}, r[15:0]};
      3'b100:  extend = {24'b0, r[7:0]};
      3'b101:  extend = {16'b0, r[15:0]};
      default: extend = r;
    endcase
  endfunction

  // Request decode: lane mask, legality and misalignment of the incoming op.
  always_comb begin
    off       = req_addr[1:0];
    word_addr = {req_addr[31:2], 2'b00};
    case (req_funct3[1:0])
      2'b00:   mask = 4'b0001;
      2'b01:   mask = 4'b0011;
      default: mask = 4'b1111;
    endcase
    lanes = {4'b0000, mask} << off;
    legal = req_store ? (req_funct3 inside {3'b000, 3'b001, 3'b010})
                      : (req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    misal  = legal && (lanes[7:4] != 4'b0000);
    accept = (state_q == IDLE) && req_valid;
    case (off)
      2'd0:    rot = req_wdata;
      2'd1:    rot = {req_wdata[23:0], req_wdata[31:24]};
      2'd2:    rot = {req_wdata[15:0], req_wdata[31:16]};
      default: rot = {req_wdata[7:0],  req_wdata[31:8]};
    endcase
  end

  // Shared load formatter: SECOND combines the captured low word with the
  // current read as the high word; an aligned load uses a zero high word.
  always_comb begin
    hi_sel    = (state_q == SECOND) ? drdata : '0;
    lo_sel    = (state_q == SECOND) ? lo_q : drdata;
    off_sel   = (state_q == SECOND) ? off_q : off;
    f3_sel    = (state_q == SECOND) ? funct3_q : req_funct3;
    raw       = 32'({hi_sel, lo_sel} >> {off_sel, 3'b000});
    load_data = extend(f3_sel, raw);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      rot_q       <= '0;
      lanes_hi_q  <= '0;
      off_q       <= '0;
      funct3_q    <= '0;
      store_q     <= 1'b0;
      addr2_q     <= '0;
      lo_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rot_q       <= rot_d;
      lanes_hi_q  <= lanes_hi_d;
      off_q       <= off_d;
      funct3_q    <= funct3_d;
      store_q     <= store_d;
      addr2_q     <= addr2_d;
      lo_q        <= lo_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && misal) state_d = SECOND;
      SECOND:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rot_d       = rot_q;
    lanes_hi_d  = lanes_hi_q;
    off_d       = off_q;
    funct3_d    = funct3_q;
    store_d     = store_q;
    addr2_d     = addr2_q;
    lo_d        = lo_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    req_ready   = (state_q == IDLE);
    daddr       = word_addr;
    dwdata      = rot;
    we          = '0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (legal && req_store) we = lanes[3:0];
          if (!legal) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else if (misal) begin
            rot_d      = rot;
            lanes_hi_d = lanes[7:4];
            off_d      = off;
            funct3_d   = req_funct3;
            store_d    = req_store;
            addr2_d    = word_addr + 32'd4;
            lo_d       = drdata;
          end else begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = req_store ? '0 : load_data;
          end
        end
      end
      SECOND: begin
        daddr       = addr2_q;
        dwdata      = rot_q;
        we          = store_q ? lanes_hi_q : '0;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = store_q ? '0 : load_data;
      end
      default: ;
    endcase
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboarded random bench for load_store_unit against a byte-array memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_store = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] daddr;
  logic [31:0] dwdata;
  logic [3:0]  we;
  logic [31:0] drdata;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .daddr(daddr), .dwdata(dwdata), .we(we), .drdata(drdata)
  );

  // dmem: 64 words, aliased on address bits [7:2]
  logic [31:0] dmem [64];
  logic [7:0]  ref_mem [256];
  logic        mem_load = 1'b0;

  assign drdata = dmem[daddr[7:2]];

  always @(posedge clk) begin
    if (mem_load) begin
      for (int w = 0; w < 64; w++)
        dmem[w] <= {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]};
    end else begin
      for (int i = 0; i < 4; i++)
        if (we[i]) dmem[daddr[7:2]][8*i +: 8] <= dwdata[8*i +: 8];
    end
  end

  int unsigned total = 0;
  int unsigned bad = 0;
  int unsigned cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int unsigned due;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int nbytes(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   nbytes = 1;
      2'b01:   nbytes = 2;
      default: nbytes = 4;
    endcase
  endfunction

  function automatic bit legal_op(input bit store, input logic [2:0] f3);
    if (store) legal_op = (f3 <= 3'd2);
    else       legal_op = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [2:0] f3);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < nbytes(f3); i++) v[8*i +: 8] = ref_mem[8'(addr + i)];
    if (f3 == 3'd0) v = {{24{v[7]}}, v[7:0]};
    if (f3 == 3'd1) v = {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!reset && rsp_valid) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response");
      end else begin
        e = sb.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
        chk("rsp_latency", cyc, e.due);
      end
    end
  end

  task automatic wait_ready();
    int guard;
    guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 8) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: got req_ready=0 expected 1");
    end
  endtask

  task automatic do_op(input bit store, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata);
    int          n, off;
    bit          ok, misal;
    exp_t        e;
    logic [3:0]  we_lo, we_hi;
    logic [31:0] exp_dw, m_lo, m_hi, word;
    wait_ready();
    req_valid  = 1'b1;
    req_store  = store;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    ok    = legal_op(store, f3);
    n     = nbytes(f3);
    off   = int'(addr[1:0]);
    misal = ok && (off + n > 4);
    word  = addr & ~32'd3;
    we_lo = '0; we_hi = '0; exp_dw = '0; m_lo = '0; m_hi = '0;
    for (int i = 0; i < n; i++) begin
      exp_dw[8*((off+i)%4) +: 8] = wdata[8*i +: 8];
      if (off + i < 4) begin
        we_lo[off+i] = 1'b1;
        m_lo[8*(off+i) +: 8] = 8'hFF;
      end else begin
        we_hi[off+i-4] = 1'b1;
        m_hi[8*(off+i-4) +: 8] = 8'hFF;
      end
    end
    if (!(ok && store)) begin
      we_lo = '0;
      we_hi = '0;
    end
    e.err   = !ok;
    e.rdata = (ok && !store) ? ref_load(addr, f3) : 32'd0;
    e.due   = cyc + (misal ? 2 : 1);
    sb.push_back(e);
    if (ok && store)
      for (int i = 0; i < n; i++) ref_mem[8'(addr + i)] = wdata[8*i +: 8];
    #1;
    chk("daddr_first", daddr, word);
    chk("we_first", {28'b0, we}, {28'b0, we_lo});
    if (ok && store) chk("dwdata_first", dwdata & m_lo, exp_dw & m_lo);
    @(posedge clk);
    #1;
    if (misal) begin
      // inputs in SECOND must be ignored, so drive junk
      req_valid  = 1'b1;
      req_store  = 1'($urandom);
      req_funct3 = 3'($urandom);
      req_addr   = $urandom;
      req_wdata  = $urandom;
      @(negedge clk);
      chk("ready_second", {31'b0, req_ready}, 32'd0);
      chk("daddr_second", daddr, word + 32'd4);
      chk("we_second", {28'b0, we}, {28'b0, we_hi});
      if (store) chk("dwdata_second", dwdata & m_hi, exp_dw & m_hi);
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
  endtask

  // Misaligned SW at 0x2E aborted by reset after its first word is written.
  task automatic reset_abort();
    logic [31:0] wd;
    wd = 32'hA1B2C3D4;
    wait_ready();
    req_valid  = 1'b1;
    req_store  = 1'b1;
    req_funct3 = 3'd2;
    req_addr   = 32'h2E;
    req_wdata  = wd;
    ref_mem[8'h2E] = wd[7:0];
    ref_mem[8'h2F] = wd[15:8];
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("abort_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("abort_ready", {31'b0, req_ready}, 32'd1);
    chk("abort_we", {28'b0, we}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #500000;
    total++;
    bad++;
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    bit          st;
    logic [2:0]  f3;
    logic [2:0]  legal_ld [5];
    legal_ld[0] = 3'd0; legal_ld[1] = 3'd1; legal_ld[2] = 3'd2;
    legal_ld[3] = 3'd4; legal_ld[4] = 3'd5;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'($urandom);
    #1;
    reset = 1'b1;
    #1;
    chk("reset_ready", {31'b0, req_ready}, 32'd1);
    chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("reset_rsp_err", {31'b0, rsp_err}, 32'd0);
    mem_load = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    mem_load = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    do_op(1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
    do_op(1'b0, 3'd2, 32'h10, 32'h0);
    do_op(1'b1, 3'd0, 32'h13, 32'h00000080);
    do_op(1'b0, 3'd0, 32'h13, 32'h0);
    do_op(1'b0, 3'd4, 32'h13, 32'h0);
    do_op(1'b1, 3'd2, 32'h06, 32'h11223344);
    do_op(1'b0, 3'd2, 32'h06, 32'h0);
    do_op(1'b1, 3'd0, 32'h0B, 32'h34);
    do_op(1'b1, 3'd0, 32'h0C, 32'h92);
    do_op(1'b0, 3'd1, 32'h0B, 32'h0);
    do_op(1'b0, 3'd5, 32'h0B, 32'h0);
    do_op(1'b1, 3'd3, 32'h20, 32'h55555555);
    do_op(1'b1, 3'd7, 32'h21, 32'h66666666);
    do_op(1'b0, 3'd3, 32'h20, 32'h0);
    do_op(1'b0, 3'd6, 32'h20, 32'h0);
    do_op(1'b0, 3'd7, 32'h20, 32'h0);
    do_op(1'b0, 3'd2, 32'h20, 32'h0);
    do_op(1'b1, 3'd2, 32'hFFFFFFFE, 32'hCAFEF00D);
    do_op(1'b0, 3'd2, 32'hFFFFFFFE, 32'h0);
    do_op(1'b0, 3'd1, 32'hFFFFFFFF, 32'h0);
    do_op(1'b0, 3'd2, 32'h0, 32'h0);

    reset_abort();
    do_op(1'b0, 3'd2, 32'h2C, 32'h0);
    do_op(1'b0, 3'd2, 32'h30, 32'h0);

    for (int k = 0; k < 400; k++) begin
      st = 1'($urandom);
      if ($urandom_range(0, 9) == 0) f3 = 3'($urandom);
      else if (st)                   f3 = 3'($urandom_range(0, 2));
      else                           f3 = legal_ld[$urandom_range(0, 4)];
      do_op(st, f3, $urandom, $urandom);
    end

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
